// File: rtl/ctrl_decode_queue.sv
// RV32I decode stage: decodes fetched words into rv32i_control_word and buffers them in a circular queue.
// Optional macro RV32M_EN makes funct7=0000001 register ops legal and flags them via out_muldiv.
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111, op_auipc = 7'b0010111, op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111, op_br    = 7'b1100011, op_load  = 7'b0000011,
    op_store = 7'b0100011, op_imm   = 7'b0010011, op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;
  typedef enum logic [2:0] {
    alu_add = 3'd0, alu_sll = 3'd1, alu_sra = 3'd2, alu_sub = 3'd3,
    alu_xor = 3'd4, alu_srl = 3'd5, alu_or  = 3'd6, alu_and = 3'd7
  } alu_ops;
  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3;
  typedef enum logic {am1_rs1_out = 1'b0, am1_pc_out = 1'b1} alumux1_sel_t;
  typedef enum logic [2:0] {
    am2_i_imm = 3'd0, am2_u_imm = 3'd1, am2_b_imm = 3'd2, am2_s_imm = 3'd3,
    am2_j_imm = 3'd4, am2_rs2_out = 3'd5
  } alumux2_sel_t;
  typedef enum logic {cmp_rs2_out = 1'b0, cmp_i_imm = 1'b1} cmpmux_sel_t;
  typedef enum logic [1:0] {pcm_pc_plus4 = 2'd0, pcm_alu_out = 2'd1, pcm_alu_mod2 = 2'd2} pcmux_sel_t;
  typedef enum logic {mar_pc_out = 1'b0, mar_alu_out = 1'b1} marmux_sel_t;
  typedef enum logic [3:0] {
    rfm_alu_out = 4'd0, rfm_br_en = 4'd1, rfm_u_imm = 4'd2, rfm_lw  = 4'd3, rfm_pc_plus4 = 4'd4,
    rfm_lb      = 4'd5, rfm_lbu   = 4'd6, rfm_lh    = 4'd7, rfm_lhu = 4'd8
  } regfilemux_sel_t;
  typedef struct packed {
    logic [6:0]      opcode;
    alu_ops          aluop;
    branch_funct3    cmpop;
    alumux1_sel_t    alumux1;
    alumux2_sel_t    alumux2;
    cmpmux_sel_t     cmpmux;
    pcmux_sel_t      pcmux;
    marmux_sel_t     marmux;
    regfilemux_sel_t regfilemux;
    logic            regfile_load;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_funct3;
  } rv32i_control_word;
endpackage

module ctrl_decode_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output rv32i_control_word out_ctrl,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic              out_illegal,
  output logic              out_muldiv,
  input  logic              flush,
  output logic [CNT_W-1:0]  illegal_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CQ_W  = $clog2(DEPTH + 1);
  localparam logic [CQ_W-1:0]  FULL_C = CQ_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C = PTR_W'(DEPTH - 1);

  typedef struct packed {
    rv32i_control_word ctrl;
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              illegal;
  } entry_t;

  entry_t            mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CQ_W-1:0]   count_r;
  logic [CNT_W-1:0]  illegal_count_r;
  rv32i_control_word dec_s, ctrl_s;
  entry_t            entry_s, head_s;
  logic              illegal_s, muldiv_s, in_fire_s, out_fire_s, is_reg_s;
  logic [2:0]        funct3_s;
  logic [6:0]        funct7_s;
  alu_ops            arith_aluop_s;
  branch_funct3      arith_cmpop_s;
  regfilemux_sel_t   arith_rfm_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_C) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign funct3_s   = in_instr[14:12];
  assign funct7_s   = in_instr[31:25];
  assign is_reg_s   = (in_instr[6:0] == op_reg);
  assign out_valid  = (count_r != '0);
  assign in_ready   = ~flush & ((count_r != FULL_C) | out_ready);
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // ALU/compare selection shared by register and immediate arithmetic
  always_comb begin
    arith_aluop_s = alu_add;
    arith_cmpop_s = beq;
    arith_rfm_s   = rfm_alu_out;
    case (funct3_s)
      3'b000: arith_aluop_s = (is_reg_s & funct7_s[5]) ? alu_sub : alu_add;
      3'b010: begin arith_cmpop_s = blt;  arith_rfm_s = rfm_br_en; end
      3'b011: begin arith_cmpop_s = bltu; arith_rfm_s = rfm_br_en; end
      3'b101: arith_aluop_s = funct7_s[5] ? alu_sra : alu_srl;
      default: arith_aluop_s = alu_ops'(funct3_s);
    endcase
  end

  // Instruction decode and legality check
  always_comb begin
    dec_s        = '0;
    dec_s.opcode = in_instr[6:0];
    illegal_s    = 1'b0;
    muldiv_s     = 1'b0;
    case (in_instr[6:0])
      op_lui: begin
        dec_s.regfilemux   = rfm_u_imm;
        dec_s.regfile_load = 1'b1;
      end
      op_auipc: begin
        dec_s.alumux1      = am1_pc_out;
        dec_s.alumux2      = am2_u_imm;
        dec_s.regfile_load = 1'b1;
      end
      op_jal: begin
        dec_s.alumux1      = am1_pc_out;
        dec_s.alumux2      = am2_j_imm;
        dec_s.pcmux        = pcm_alu_out;
        dec_s.regfilemux   = rfm_pc_plus4;
        dec_s.regfile_load = 1'b1;
      end
      op_jalr: begin
        if (funct3_s == 3'b000) begin
          dec_s.alumux2      = am2_i_imm;
          dec_s.pcmux        = pcm_alu_mod2;
          dec_s.regfilemux   = rfm_pc_plus4;
          dec_s.regfile_load = 1'b1;
        end else begin
          illegal_s = 1'b1;
        end
      end
      op_br: begin
        if ((funct3_s == 3'b010) || (funct3_s == 3'b011)) begin
          illegal_s = 1'b1;
        end else begin
          dec_s.alumux1 = am1_pc_out;
          dec_s.alumux2 = am2_b_imm;
          dec_s.cmpop   = branch_funct3'(funct3_s);
          dec_s.pcmux   = pcm_alu_out;
        end
      end
      op_load: begin
        dec_s.alumux2      = am2_i_imm;
        dec_s.marmux       = mar_alu_out;
        dec_s.mem_read     = 1'b1;
        dec_s.regfile_load = 1'b1;
        dec_s.mem_funct3   = funct3_s;
        case (funct3_s)
          3'b000:  dec_s.regfilemux = rfm_lb;
          3'b001:  dec_s.regfilemux = rfm_lh;
          3'b010:  dec_s.regfilemux = rfm_lw;
          3'b100:  dec_s.regfilemux = rfm_lbu;
          3'b101:  dec_s.regfilemux = rfm_lhu;
          default: illegal_s = 1'b1;
        endcase
      end
      op_store: begin
        if (funct3_s > 3'b010) begin
          illegal_s = 1'b1;
        end else begin
          dec_s.alumux2    = am2_s_imm;
          dec_s.marmux     = mar_alu_out;
          dec_s.mem_write  = 1'b1;
          dec_s.mem_funct3 = funct3_s;
        end
      end
      op_imm: begin
        if (((funct3_s == 3'b001) && (funct7_s != 7'b0000000)) ||
            ((funct3_s == 3'b101) && (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000))) begin
          illegal_s = 1'b1;
        end else begin
          dec_s.alumux2      = am2_i_imm;
          dec_s.cmpmux       = cmp_i_imm;
          dec_s.aluop        = arith_aluop_s;
          dec_s.cmpop        = arith_cmpop_s;
          dec_s.regfilemux   = arith_rfm_s;
          dec_s.regfile_load = 1'b1;
        end
      end
      op_reg: begin
        if ((funct7_s == 7'b0000000) ||
            ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)))) begin
          dec_s.alumux2      = am2_rs2_out;
          dec_s.cmpmux       = cmp_rs2_out;
          dec_s.aluop        = arith_aluop_s;
          dec_s.cmpop        = arith_cmpop_s;
          dec_s.regfilemux   = arith_rfm_s;
          dec_s.regfile_load = 1'b1;
`ifdef RV32M_EN
        end else if (funct7_s == 7'b0000001) begin
          // aluop carries funct3 as the mul/div selector for the M unit
          muldiv_s           = 1'b1;
          dec_s.aluop        = alu_ops'(funct3_s);
          dec_s.alumux1      = am1_rs1_out;
          dec_s.alumux2      = am2_rs2_out;
          dec_s.regfile_load = 1'b1;
`endif
        end else begin
          illegal_s = 1'b1;
        end
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Illegal entries keep only the raw opcode so execute can still identify them
  always_comb begin
    if (illegal_s) begin
      ctrl_s        = '0;
      ctrl_s.opcode = in_instr[6:0];
    end else begin
      ctrl_s = dec_s;
    end
    entry_s.ctrl    = ctrl_s;
    entry_s.pc      = in_pc;
    entry_s.instr   = in_instr;
    entry_s.illegal = illegal_s;
  end

  // Queue storage; contents are don't-care outside the live window so no reset
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

`ifdef RV32M_EN
  logic muldiv_r [DEPTH];

  // Per-entry M-extension flag
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      muldiv_r[wr_ptr_r] <= muldiv_s;
    end
  end
  assign out_muldiv = muldiv_r[rd_ptr_r];
`else
  assign out_muldiv = 1'b0;
`endif

  // Pointer and occupancy tracking; flush wins over push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= in_fire_s  ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r <= out_fire_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      case ({in_fire_s, out_fire_s})
        2'b10:   count_r <= count_r + CQ_W'(1);
        2'b01:   count_r <= count_r - CQ_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating illegal counter; a pop coinciding with flush still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_count_r <= '0;
    end else if (out_fire_s && head_s.illegal && (illegal_count_r != {CNT_W{1'b1}})) begin
      illegal_count_r <= illegal_count_r + CNT_W'(1);
    end else begin
      illegal_count_r <= illegal_count_r;
    end
  end

  assign head_s        = mem_r[rd_ptr_r];
  assign out_ctrl      = head_s.ctrl;
  assign out_pc        = head_s.pc;
  assign out_instr     = head_s.instr;
  assign out_illegal   = head_s.illegal;
  assign illegal_count = illegal_count_r;
endmodule

// File: tb/tb_ctrl_decode_queue.sv
// Self-checking bench for ctrl_decode_queue: directed scenarios plus random traffic against a queue model.
// Expectations follow RV32M_EN when the macro is defined for the build.
module tb_ctrl_decode_queue;
  import rv32i_types::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  typedef struct {
    rv32i_control_word ctrl;
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              illegal;
    logic              muldiv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, out_illegal, out_muldiv, flush;
  logic [31:0] in_instr, in_pc, out_pc, out_instr;
  rv32i_control_word out_ctrl;
  logic [CNT_W-1:0] illegal_count;

  int checks = 0;
  int failures = 0;
  exp_t mq[$];
  int mcnt = 0;
  logic [6:0] ops [9];

  ctrl_decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_pc(out_pc), .out_instr(out_instr), .out_illegal(out_illegal),
    .out_muldiv(out_muldiv), .flush(flush), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the encoding rules
  function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    rv32i_control_word c;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic bad, m_ok;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    m_ok = M_EN && (op == op_reg) && (f7 == 7'h01);
    case (op)
      op_lui, op_auipc, op_jal: bad = 1'b0;
      op_jalr:  bad = (f3 != 3'd0);
      op_br:    bad = (f3 inside {3'd2, 3'd3});
      op_load:  bad = (f3 inside {3'd3, 3'd6, 3'd7});
      op_store: bad = (f3 > 3'd2);
      op_imm:   bad = ((f3 == 3'd1) && (f7 != 7'h00)) || ((f3 == 3'd5) && !(f7 inside {7'h00, 7'h20}));
      op_reg:   bad = !m_ok && (!(f7 inside {7'h00, 7'h20}) || ((f7 == 7'h20) && !(f3 inside {3'd0, 3'd5})));
      default:  bad = 1'b1;
    endcase
    c = '0;
    c.opcode = op;
    if (!bad) begin
      case (op)
        op_lui:   begin c.regfilemux = rfm_u_imm; c.regfile_load = 1'b1; end
        op_auipc: begin c.alumux1 = am1_pc_out; c.alumux2 = am2_u_imm; c.regfile_load = 1'b1; end
        op_jal:   begin c.alumux1 = am1_pc_out; c.alumux2 = am2_j_imm; c.pcmux = pcm_alu_out;
                        c.regfilemux = rfm_pc_plus4; c.regfile_load = 1'b1; end
        op_jalr:  begin c.alumux2 = am2_i_imm; c.pcmux = pcm_alu_mod2;
                        c.regfilemux = rfm_pc_plus4; c.regfile_load = 1'b1; end
        op_br:    begin c.alumux1 = am1_pc_out; c.alumux2 = am2_b_imm;
                        c.cmpop = branch_funct3'(f3); c.pcmux = pcm_alu_out; end
        op_load: begin
          c.marmux = mar_alu_out; c.mem_read = 1'b1; c.regfile_load = 1'b1; c.mem_funct3 = f3;
          case (f3)
            3'd0: c.regfilemux = rfm_lb;
            3'd1: c.regfilemux = rfm_lh;
            3'd2: c.regfilemux = rfm_lw;
            3'd4: c.regfilemux = rfm_lbu;
            default: c.regfilemux = rfm_lhu;
          endcase
        end
        op_store: begin c.alumux2 = am2_s_imm; c.marmux = mar_alu_out; c.mem_write = 1'b1; c.mem_funct3 = f3; end
        default: begin
          c.regfile_load = 1'b1;
          if (m_ok) begin
            c.aluop = alu_ops'(f3); c.alumux2 = am2_rs2_out;
          end else begin
            c.alumux2 = (op == op_reg) ? am2_rs2_out : am2_i_imm;
            c.cmpmux  = (op == op_reg) ? cmp_rs2_out : cmp_i_imm;
            if (f3 == 3'd2)      begin c.cmpop = blt;  c.regfilemux = rfm_br_en; end
            else if (f3 == 3'd3) begin c.cmpop = bltu; c.regfilemux = rfm_br_en; end
            else if (f3 == 3'd5) c.aluop = f7[5] ? alu_sra : alu_srl;
            else if (f3 == 3'd0) c.aluop = ((op == op_reg) && f7[5]) ? alu_sub : alu_add;
            else c.aluop = alu_ops'(f3);
          end
        end
      endcase
    end
    e.ctrl = c; e.pc = pc; e.instr = w; e.illegal = bad; e.muldiv = m_ok;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 9);
    if (r < 9) w[6:0] = ops[r];
    r = $urandom_range(0, 3);
    if (r == 0) w[31:25] = 7'h00;
    else if (r == 1) w[31:25] = 7'h20;
    else if (r == 2) w[31:25] = 7'h01;
    return w;
  endfunction

  // Model state advances on each clock using the model's own occupancy
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      bit pop, push;
      pop  = (mq.size() != 0) && out_ready;
      push = in_valid && !flush && ((mq.size() != DEPTH) || out_ready);
      if (pop) begin
        if (mq[0].illegal && (mcnt < CMAX)) mcnt++;
        void'(mq.pop_front());
      end
      if (flush) mq.delete();
      else if (push) mq.push_back(model_decode(in_instr, in_pc));
    end
  end

  // Every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, !flush && ((mq.size() != DEPTH) || out_ready));
      check("out_valid", out_valid, mq.size() != 0);
      check("illegal_count", illegal_count, mcnt);
      if (mq.size() != 0) begin
        check("out_pc", out_pc, mq[0].pc);
        check("out_instr", out_instr, mq[0].instr);
        check("out_illegal", out_illegal, mq[0].illegal);
        check("out_ctrl", out_ctrl, mq[0].ctrl);
        check("out_muldiv", out_muldiv, mq[0].muldiv);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = w; in_pc = pc;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    ops = '{op_lui, op_auipc, op_jal, op_jalr, op_br, op_load, op_store, op_imm, op_reg};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_instr = '0; in_pc = '0;

    // Pin the reference decode with hand-derived values
    e = model_decode(32'h00500093, 32'h0);
    check("pin_addi_illegal", e.illegal, 1'b0);
    check("pin_addi_ctrl", e.ctrl, {7'h13, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 3'd0});
    e = model_decode(32'h0000006F, 32'h0);
    check("pin_jal_ctrl", e.ctrl, {7'h6F, 3'd0, 3'd0, 1'b1, 3'd4, 1'b0, 2'd1, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 3'd0});
    e = model_decode(32'h02000033, 32'h0);
    check("pin_mul_illegal", e.illegal, !M_EN);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single addi held at the head with execute stalled
    push(32'h00500093, 32'h100);
    check("addi_valid", out_valid, 1'b1);
    check("addi_illegal", out_illegal, 1'b0);
    check("addi_opcode", out_ctrl.opcode, 7'h13);
    check("addi_rf_load", out_ctrl.regfile_load, 1'b1);
    check("addi_alumux2", out_ctrl.alumux2, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("addi_hold_pc", out_pc, 32'h100);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Full queue, then simultaneous push/pop across pointer wrap
    push(32'h00500093, 32'h200);
    push(32'h00208113, 32'h204);
    check("full_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    push(32'h00310193, 32'h208);
    check("wrap_head1", out_pc, 32'h204);
    push(32'h00418213, 32'h20C);
    check("wrap_head2", out_pc, 32'h208);
    step(); step();
    out_ready = 1'b0;

    // Illegal word followed by a mul encoding
    push(32'hFFFFFFFF, 32'h300);
    push(32'h02000033, 32'h304);
    check("ill_first", out_illegal, 1'b1);
    out_ready = 1'b1; step();
    check("mul_illegal", out_illegal, !M_EN);
    check("mul_muldiv", out_muldiv, M_EN);
    step(); out_ready = 1'b0;
    check("ill_count", illegal_count, M_EN ? 2'd1 : 2'd2);

    // Asynchronous reset with a full queue
    push(32'h00500093, 32'h500);
    push(32'hFFFFFFFF, 32'h504);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_count", illegal_count, 2'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Flush with an in-flight instruction
    push(32'h00500093, 32'h600);
    push(32'h00500093, 32'h604);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h608;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_empty", out_valid, 1'b0);
    step();
    check("flush_dropped", out_valid, 1'b0);

    // Five illegal pops saturate a 2-bit counter
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; out_ready = 1'b1;
    repeat (5) step();
    in_valid = 1'b0;
    repeat (2) step();
    check("sat_count", illegal_count, 2'd3);
    out_ready = 1'b0;

    // Random traffic with one reset pulse midway
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_n = 1'b0; step(); rst_n = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
